// File: rtl/dfi_sram_responder.sv
// dfi_sram_responder: DDR3 PHY+SDRAM stand-in on the DFI side of the controller.
// Tracks bank state, queues RD/WR burst addresses and serves bursts from on-chip SRAM.
module dfi_sram_responder #(
    parameter int DDR_ROW_BITS   = 13,
    parameter int DDR_COL_BITS   = 10,
    parameter int MEM_ABITS      = 10,
    parameter int RD_DELAY       = 3,
    parameter int CMD_FIFO_DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    dfi_rst_ni,
    input  logic                    dfi_cke_i,
    input  logic                    dfi_cs_ni,
    input  logic                    dfi_ras_ni,
    input  logic                    dfi_cas_ni,
    input  logic                    dfi_we_ni,
    input  logic                    dfi_odt_i,
    input  logic [2:0]              dfi_bank_i,
    input  logic [DDR_ROW_BITS-1:0] dfi_addr_i,
    input  logic                    dfi_wstb_i,
    input  logic                    dfi_wren_i,
    input  logic [3:0]              dfi_mask_i,
    input  logic [31:0]             dfi_data_i,
    input  logic                    dfi_rden_i,
    output logic                    dfi_rvld_o,
    output logic                    dfi_last_o,
    output logic [31:0]             dfi_data_o,
    output logic                    err_o
);

    localparam int FULL_BITS = DDR_ROW_BITS + DDR_COL_BITS + 2;
    localparam int PW        = $clog2(CMD_FIFO_DEPTH);
    localparam int CW        = PW + 1;
    localparam int SRW       = RD_DELAY - 1;
    localparam int BW        = MEM_ABITS - 2;
    localparam logic [CW-1:0] FULL_CNT = CW'(CMD_FIFO_DEPTH);

    typedef logic [BW-1:0] base_t;

    logic rst;
    assign rst = !reset_n || !dfi_rst_ni;

    // Command decode
    logic [3:0] cmd;
    logic       cmd_act;
    logic       cmd_pre;
    logic       cmd_rd;
    logic       cmd_wr;
    logic       cmd_ref;
    logic       a10;

    assign cmd     = {dfi_cs_ni, dfi_ras_ni, dfi_cas_ni, dfi_we_ni};
    assign cmd_act = dfi_cke_i && (cmd == 4'b0011);
    assign cmd_pre = dfi_cke_i && (cmd == 4'b0010);
    assign cmd_rd  = dfi_cke_i && (cmd == 4'b0101);
    assign cmd_wr  = dfi_cke_i && (cmd == 4'b0100);
    assign cmd_ref = dfi_cke_i && (cmd == 4'b0001);
    assign a10     = dfi_addr_i[10];

    // Bank state
    logic [7:0]              open_q;
    logic [7:0]              open_d;
    logic [DDR_ROW_BITS-1:0] row_q [8];
    logic                    bank_open;
    logic [FULL_BITS-1:0]    full_addr;
    base_t                   cmd_base;

    assign bank_open = open_q[dfi_bank_i];
    assign full_addr = {dfi_bank_i, row_q[dfi_bank_i],
                        dfi_addr_i[DDR_COL_BITS-1:3], 2'b00};
    assign cmd_base  = full_addr[MEM_ABITS-1:2];

    // Pending burst-address queues
    base_t           rdf_q [CMD_FIFO_DEPTH];
    base_t           wrf_q [CMD_FIFO_DEPTH];
    logic [PW-1:0]   rd_wp_q;
    logic [PW-1:0]   rd_wp_d;
    logic [PW-1:0]   rd_rp_q;
    logic [PW-1:0]   rd_rp_d;
    logic [PW-1:0]   wr_wp_q;
    logic [PW-1:0]   wr_wp_d;
    logic [PW-1:0]   wr_rp_q;
    logic [PW-1:0]   wr_rp_d;
    logic [CW-1:0]   rd_cnt_q;
    logic [CW-1:0]   rd_cnt_d;
    logic [CW-1:0]   wr_cnt_q;
    logic [CW-1:0]   wr_cnt_d;
    logic            rd_full;
    logic            wr_full;
    logic            rd_empty;
    logic            wr_empty;
    logic            rd_push;
    logic            wr_push;
    logic            rd_pop;
    logic            wr_pop;

    assign rd_full  = (rd_cnt_q == FULL_CNT);
    assign wr_full  = (wr_cnt_q == FULL_CNT);
    assign rd_empty = (rd_cnt_q == '0);
    assign wr_empty = (wr_cnt_q == '0);
    assign rd_push  = cmd_rd && bank_open && !rd_full;
    assign wr_push  = cmd_wr && bank_open && !wr_full;

    // Write path
    logic [1:0]           wbeat_q;
    logic [1:0]           wbeat_d;
    logic                 wr_do;
    logic                 wr_err;
    logic [MEM_ABITS-1:0] waddr;

    assign wr_do  = dfi_wren_i && !wr_empty;
    assign wr_err = dfi_wren_i && wr_empty;
    assign wr_pop = wr_do && (wbeat_q == 2'd3);
    assign waddr  = {wrf_q[wr_rp_q], wbeat_q};

    // Read path: the last shift stage launches the SRAM read
    logic [SRW-1:0]       rsr_q;
    logic [SRW-1:0]       rsr_d;
    logic [1:0]           rbeat_q;
    logic [1:0]           rbeat_d;
    logic                 issue;
    logic                 rd_err;
    logic [MEM_ABITS-1:0] raddr;

    assign issue  = rsr_q[SRW-1];
    assign rd_err = issue && rd_empty;
    assign rd_pop = issue && !rd_empty && (rbeat_q == 2'd3);
    assign raddr  = {rdf_q[rd_rp_q], rbeat_q};

    logic        rvld_q;
    logic        last_q;
    logic        err_q;
    logic        err_d;
    logic        cmd_err;
    logic [31:0] data_q;
    logic [31:0] mem_q [2**MEM_ABITS];

    always_comb begin
        open_d = open_q;
        unique case (1'b1)
            cmd_act: open_d[dfi_bank_i] = 1'b1;
            cmd_pre: begin
                if (a10) begin
                    open_d = '0;
                end else begin
                    open_d[dfi_bank_i] = 1'b0;
                end
            end
            cmd_rd:  if (rd_push && a10) open_d[dfi_bank_i] = 1'b0;
            cmd_wr:  if (wr_push && a10) open_d[dfi_bank_i] = 1'b0;
            default: ;
        endcase
    end

    always_comb begin
        cmd_err = ((cmd_rd || cmd_wr) && !bank_open)
                || (cmd_rd && bank_open && rd_full)
                || (cmd_wr && bank_open && wr_full)
                || (cmd_ref && (open_q != '0));
        err_d    = err_q || cmd_err || wr_err || rd_err;
        rd_wp_d  = rd_wp_q + PW'(rd_push);
        rd_rp_d  = rd_rp_q + PW'(rd_pop);
        wr_wp_d  = wr_wp_q + PW'(wr_push);
        wr_rp_d  = wr_rp_q + PW'(wr_pop);
        rd_cnt_d = rd_cnt_q + CW'(rd_push) - CW'(rd_pop);
        wr_cnt_d = wr_cnt_q + CW'(wr_push) - CW'(wr_pop);
        wbeat_d  = wr_do ? wbeat_q + 2'd1 : wbeat_q;
        rbeat_d  = issue ? rbeat_q + 2'd1 : rbeat_q;
        rsr_d    = SRW'({rsr_q, dfi_rden_i});
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            open_q   <= '0;
            rd_wp_q  <= '0;
            rd_rp_q  <= '0;
            wr_wp_q  <= '0;
            wr_rp_q  <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            wbeat_q  <= '0;
            rbeat_q  <= '0;
            rsr_q    <= '0;
            rvld_q   <= 1'b0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            open_q   <= open_d;
            rd_wp_q  <= rd_wp_d;
            rd_rp_q  <= rd_rp_d;
            wr_wp_q  <= wr_wp_d;
            wr_rp_q  <= wr_rp_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            wbeat_q  <= wbeat_d;
            rbeat_q  <= rbeat_d;
            rsr_q    <= rsr_d;
            rvld_q   <= issue;
            last_q   <= issue && (rbeat_q == 2'd3);
            err_q    <= err_d;
        end
    end

    // Storage without reset: row addresses, queue slots and SRAM
    always_ff @(posedge clock) begin
        if (!rst && cmd_act) row_q[dfi_bank_i] <= dfi_addr_i;
        if (!rst && rd_push) rdf_q[rd_wp_q] <= cmd_base;
        if (!rst && wr_push) wrf_q[wr_wp_q] <= cmd_base;
    end

    always_ff @(posedge clock) begin
        if (!rst && wr_do) begin
            for (int i = 0; i < 4; i++) begin
                if (!dfi_mask_i[i]) mem_q[waddr][8*i +: 8] <= dfi_data_i[8*i +: 8];
            end
        end
    end

    // Read-before-write: a same-edge write is not visible here
    always_ff @(posedge clock) begin
        if (rst) begin
            data_q <= '0;
        end else if (issue) begin
            data_q <= rd_empty ? '0 : mem_q[raddr];
        end
    end

    logic unused_ok;
    assign unused_ok = ^{dfi_odt_i, dfi_wstb_i,
                         full_addr[FULL_BITS-1:MEM_ABITS], full_addr[1:0]};

    assign dfi_rvld_o = rvld_q;
    assign dfi_last_o = last_q;
    assign dfi_data_o = data_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_dfi_sram_responder.sv
// Bench for dfi_sram_responder: three instances (RD_DELAY 3, 2, 5) share stimulus
// and are checked against a burst-level reference model plus directed sequences.
module tb_dfi_sram_responder;

    localparam int NI = 3;
    localparam logic [3:0] C_MRS = 4'b0000;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_NOP = 4'b0111;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n, dfi_rst_n, cke, cs_n, ras_n, cas_n, we_n;
    logic        odt, wstb, wren, rden;
    logic [2:0]  bank;
    logic [12:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic        rvld_w [NI];
    logic        last_w [NI];
    logic        err_w  [NI];
    logic [31:0] dout_w [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dfi_sram_responder #(
            .RD_DELAY(g == 0 ? 3 : (g == 1 ? 2 : 5))
        ) u_dut (
            .clock(clock), .reset_n(reset_n), .dfi_rst_ni(dfi_rst_n),
            .dfi_cke_i(cke), .dfi_cs_ni(cs_n), .dfi_ras_ni(ras_n),
            .dfi_cas_ni(cas_n), .dfi_we_ni(we_n), .dfi_odt_i(odt),
            .dfi_bank_i(bank), .dfi_addr_i(addr), .dfi_wstb_i(wstb),
            .dfi_wren_i(wren), .dfi_mask_i(mask), .dfi_data_i(wdata),
            .dfi_rden_i(rden), .dfi_rvld_o(rvld_w[g]), .dfi_last_o(last_w[g]),
            .dfi_data_o(dout_w[g]), .err_o(err_w[g])
        );
    end

    int dly [NI] = '{3, 2, 5};

    // Reference model state
    bit          m_open [NI][8];
    int          m_row  [NI][8];
    int          m_rdq  [NI][$];
    int          m_wrq  [NI][$];
    int          m_due  [NI][$];
    int          m_wb   [NI];
    int          m_rb   [NI];
    bit          m_err  [NI];
    logic [31:0] m_mem  [NI][1024];
    bit          m_kn   [NI][1024];
    bit          e_rvld [NI];
    bit          e_last [NI];
    logic [31:0] e_data [NI];
    bit          e_dk   [NI];

    int stepn = 0;
    int tests = 0;
    int fails = 0;

    logic [31:0] cap_d [NI][32];
    bit          cap_l [NI][32];
    int          cap_s [NI][32];
    int          cap_n [NI];
    logic [31:0] exp_d [32];

    typedef struct {
        logic [3:0] c;
        logic       ke;
        int         b;
        int         a;
        logic       exp_err;
    } vec_t;
    vec_t tbl [10];

    function automatic int base_of(input int b, input int row, input int a);
        return ((b << 22) | (row << 9) | (((a >> 3) & 127) << 2)) & 1023;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s[%0d] got %h expected %h at step %0d", nm, k, got, exp, stepn);
        end
    endtask

    task automatic model_step(input int k);
        int a;
        int b;
        bit issue;
        bit rpop;
        bit wpop;
        bit any;
        logic [3:0] c;
        if (!reset_n || !dfi_rst_n) begin
            for (int i = 0; i < 8; i++) m_open[k][i] = 0;
            m_rdq[k].delete();
            m_wrq[k].delete();
            m_due[k].delete();
            m_wb[k] = 0;
            m_rb[k] = 0;
            m_err[k] = 0;
            e_rvld[k] = 0;
            e_last[k] = 0;
            e_data[k] = 0;
            e_dk[k] = 1;
            return;
        end
        rpop = 0;
        wpop = 0;
        issue = (m_due[k].size() > 0) && (m_due[k][0] == stepn);
        e_rvld[k] = issue;
        e_last[k] = issue && (m_rb[k] == 3);
        if (issue) begin
            void'(m_due[k].pop_front());
            if (m_rdq[k].size() == 0) begin
                m_err[k] = 1;
                e_data[k] = 0;
                e_dk[k] = 1;
            end else begin
                a = (m_rdq[k][0] + m_rb[k]) % 1024;
                e_data[k] = m_mem[k][a];
                e_dk[k] = m_kn[k][a];
                rpop = (m_rb[k] == 3);
            end
            m_rb[k] = (m_rb[k] + 1) % 4;
        end
        if (wren) begin
            if (m_wrq[k].size() == 0) begin
                m_err[k] = 1;
            end else begin
                a = (m_wrq[k][0] + m_wb[k]) % 1024;
                for (int by = 0; by < 4; by++)
                    if (!mask[by]) m_mem[k][a][8*by +: 8] = wdata[8*by +: 8];
                m_kn[k][a] = m_kn[k][a] || (mask == 4'h0);
                wpop = (m_wb[k] == 3);
                m_wb[k] = (m_wb[k] + 1) % 4;
            end
        end
        if (cke) begin
            b = int'(bank);
            c = {cs_n, ras_n, cas_n, we_n};
            case (c)
                C_ACT: begin
                    m_open[k][b] = 1;
                    m_row[k][b] = int'(addr);
                end
                C_PRE: begin
                    if (addr[10]) begin
                        for (int i = 0; i < 8; i++) m_open[k][i] = 0;
                    end else begin
                        m_open[k][b] = 0;
                    end
                end
                C_RD, C_WR: begin
                    if (!m_open[k][b]) begin
                        m_err[k] = 1;
                    end else if ((c == C_RD ? m_rdq[k].size() : m_wrq[k].size()) >= 4) begin
                        m_err[k] = 1;
                    end else begin
                        if (c == C_RD) m_rdq[k].push_back(base_of(b, m_row[k][b], int'(addr)));
                        else m_wrq[k].push_back(base_of(b, m_row[k][b], int'(addr)));
                        if (addr[10]) m_open[k][b] = 0;
                    end
                end
                C_REF: begin
                    any = 0;
                    for (int i = 0; i < 8; i++) any = any | m_open[k][i];
                    if (any) m_err[k] = 1;
                end
                default: ;
            endcase
        end
        if (rpop) void'(m_rdq[k].pop_front());
        if (wpop) void'(m_wrq[k].pop_front());
        if (rden) m_due[k].push_back(stepn + dly[k] - 1);
    endtask

    task automatic cyc();
        for (int k = 0; k < NI; k++) model_step(k);
        stepn++;
        @(posedge clock);
        @(negedge clock);
        for (int k = 0; k < NI; k++) begin
            chk("rvld", k, rvld_w[k], e_rvld[k]);
            chk("last", k, last_w[k], e_last[k]);
            chk("err", k, err_w[k], m_err[k]);
            if (e_dk[k]) chk("data", k, dout_w[k], e_data[k]);
            if (rvld_w[k] && cap_n[k] < 32) begin
                cap_d[k][cap_n[k]] = dout_w[k];
                cap_l[k][cap_n[k]] = last_w[k];
                cap_s[k][cap_n[k]] = stepn - 1;
                cap_n[k]++;
            end
        end
    endtask

    task automatic cmd(input logic [3:0] c, input int b, input int a);
        {cs_n, ras_n, cas_n, we_n} = c;
        bank = 3'(b);
        addr = 13'(a);
        cyc();
        {cs_n, ras_n, cas_n, we_n} = C_NOP;
    endtask

    task automatic wbeat(input logic [31:0] d, input logic [3:0] m);
        wren = 1;
        wdata = d;
        mask = m;
        cyc();
        wren = 0;
    endtask

    task automatic rd_n(input int n);
        rden = 1;
        repeat (n) cyc();
        rden = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic pulse_reset(input int which);
        if (which == 0) reset_n = 0;
        else dfi_rst_n = 0;
        cyc();
        reset_n = 1;
        dfi_rst_n = 1;
    endtask

    task automatic clear_cap();
        for (int k = 0; k < NI; k++) cap_n[k] = 0;
    endtask

    task automatic chk_err_all(input string nm, input logic e);
        for (int k = 0; k < NI; k++) chk(nm, k, err_w[k], e);
    endtask

    task automatic chk_burst(input string nm, input int t, input int n);
        for (int k = 0; k < NI; k++) begin
            chk({nm, "_beats"}, k, cap_n[k], n);
            for (int i = 0; i < n && i < cap_n[k]; i++) begin
                chk({nm, "_data"}, k, cap_d[k][i], exp_d[i]);
                chk({nm, "_last"}, k, cap_l[k][i], (i % 4) == 3);
                chk({nm, "_when"}, k, cap_s[k][i], t + dly[k] - 1 + i);
            end
        end
    endtask

    initial begin
        int t;
        int r;
        reset_n = 0;
        dfi_rst_n = 1;
        cke = 1;
        {cs_n, ras_n, cas_n, we_n} = C_NOP;
        odt = 0;
        wstb = 0;
        bank = 0;
        addr = 0;
        wren = 0;
        rden = 0;
        mask = 0;
        wdata = 0;
        for (int k = 0; k < NI; k++) cap_n[k] = 0;

        tbl[0] = '{C_NOP, 1'b1, 0, 0, 1'b0};
        tbl[1] = '{C_REF, 1'b1, 0, 0, 1'b0};
        tbl[2] = '{C_MRS, 1'b1, 0, 'h123, 1'b0};
        tbl[3] = '{C_ACT, 1'b1, 1, 'h100, 1'b0};
        tbl[4] = '{C_PRE, 1'b1, 1, 'h000, 1'b0};
        tbl[5] = '{C_RD,  1'b0, 1, 'h010, 1'b0};
        tbl[6] = '{C_REF, 1'b1, 0, 0, 1'b0};
        tbl[7] = '{C_ACT, 1'b0, 3, 'h010, 1'b0};
        tbl[8] = '{C_WR,  1'b1, 3, 'h010, 1'b1};
        tbl[9] = '{C_ACT, 1'b1, 3, 'h010, 1'b1};

        idle(2);
        reset_n = 1;
        for (int k = 0; k < NI; k++) begin
            chk("rst_rvld", k, rvld_w[k], 0);
            chk("rst_last", k, last_w[k], 0);
            chk("rst_data", k, dout_w[k], 0);
            chk("rst_err", k, err_w[k], 0);
        end

        for (int i = 0; i < 10; i++) begin
            cke = tbl[i].ke;
            cmd(tbl[i].c, tbl[i].b, tbl[i].a);
            cke = 1;
            chk("tbl_err", 0, err_w[0], tbl[i].exp_err);
        end
        pulse_reset(0);

        // Basic write then read burst
        cmd(C_ACT, 2, 'h55);
        cmd(C_WR, 2, 'h10);
        wbeat(32'h11111111, 4'h0);
        wbeat(32'h22222222, 4'h0);
        wbeat(32'h33333333, 4'h0);
        wbeat(32'h44444444, 4'h0);
        cmd(C_RD, 2, 'h10);
        clear_cap();
        t = stepn;
        rd_n(4);
        idle(8);
        exp_d[0] = 32'h11111111;
        exp_d[1] = 32'h22222222;
        exp_d[2] = 32'h33333333;
        exp_d[3] = 32'h44444444;
        chk_burst("basic", t, 4);
        chk_err_all("basic_err", 1'b0);

        // Byte-masked write on beat 0
        cmd(C_WR, 2, 'h10);
        wbeat(32'hAABBCCDD, 4'b0101);
        wbeat(32'h0, 4'hF);
        wbeat(32'h0, 4'hF);
        wbeat(32'h0, 4'hF);
        cmd(C_RD, 2, 'h10);
        clear_cap();
        t = stepn;
        rd_n(4);
        idle(8);
        exp_d[0] = 32'hAA11CC11;
        chk_burst("mask", t, 4);

        // Closed-bank read, sticky error, reset keeps SRAM
        cmd(C_RD, 5, 'h10);
        idle(3);
        chk_err_all("closed_err", 1'b1);
        pulse_reset(0);
        for (int k = 0; k < NI; k++) begin
            chk("rst2_err", k, err_w[k], 0);
            chk("rst2_rvld", k, rvld_w[k], 0);
        end
        cmd(C_ACT, 2, 'h55);
        cmd(C_RD, 2, 'h10);
        clear_cap();
        t = stepn;
        rd_n(4);
        idle(8);
        chk_burst("keep", t, 4);

        // Two back-to-back bursts
        cmd(C_WR, 2, 'h000);
        for (int i = 0; i < 4; i++) wbeat(32'hA0000000 + i, 4'h0);
        cmd(C_WR, 2, 'h008);
        for (int i = 0; i < 4; i++) wbeat(32'hB0000000 + i, 4'h0);
        cmd(C_RD, 2, 'h000);
        cmd(C_RD, 2, 'h008);
        clear_cap();
        t = stepn;
        rd_n(8);
        idle(10);
        for (int i = 0; i < 4; i++) begin
            exp_d[i] = 32'hA0000000 + i;
            exp_d[4 + i] = 32'hB0000000 + i;
        end
        chk_burst("b2b", t, 8);

        // Auto-precharge and precharge-all
        cmd(C_WR, 2, 'h420);
        for (int i = 0; i < 4; i++) wbeat(32'hC0000000 + i, 4'h0);
        cmd(C_RD, 2, 'h020);
        chk_err_all("ap_err", 1'b1);
        pulse_reset(1);
        cmd(C_ACT, 1, 'h11);
        cmd(C_ACT, 4, 'h22);
        cmd(C_PRE, 0, 'h400);
        cmd(C_REF, 0, 0);
        chk_err_all("prea_ref", 1'b0);
        cmd(C_RD, 1, 0);
        chk_err_all("prea_b1", 1'b1);
        pulse_reset(0);
        cmd(C_RD, 4, 0);
        chk_err_all("prea_b4", 1'b1);

        // Queue overflow: fifth RD dropped
        pulse_reset(0);
        cmd(C_ACT, 2, 'h55);
        cmd(C_RD, 2, 'h10);
        cmd(C_RD, 2, 'h00);
        cmd(C_RD, 2, 'h08);
        cmd(C_RD, 2, 'h10);
        chk_err_all("q4_err", 1'b0);
        cmd(C_RD, 2, 'h18);
        chk_err_all("q5_err", 1'b1);
        clear_cap();
        t = stepn;
        rd_n(16);
        idle(10);
        exp_d[0] = 32'hAA11CC11;
        exp_d[1] = 32'h22222222;
        exp_d[2] = 32'h33333333;
        exp_d[3] = 32'h44444444;
        for (int i = 0; i < 4; i++) begin
            exp_d[4 + i] = 32'hA0000000 + i;
            exp_d[8 + i] = 32'hB0000000 + i;
            exp_d[12 + i] = exp_d[i];
        end
        chk_burst("ovf", t, 16);

        // Randomized traffic against the model
        pulse_reset(0);
        for (int n = 0; n < 2000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 10) {cs_n, ras_n, cas_n, we_n} = C_ACT;
            else if (r < 15) {cs_n, ras_n, cas_n, we_n} = C_PRE;
            else if (r < 25) {cs_n, ras_n, cas_n, we_n} = C_RD;
            else if (r < 35) {cs_n, ras_n, cas_n, we_n} = C_WR;
            else if (r < 37) {cs_n, ras_n, cas_n, we_n} = C_REF;
            else if (r < 39) {cs_n, ras_n, cas_n, we_n} = C_MRS;
            else {cs_n, ras_n, cas_n, we_n} = C_NOP;
            bank = 3'($urandom_range(0, 3));
            addr = 13'($urandom_range(0, 8191));
            cke = ($urandom_range(0, 19) != 0);
            wren = ($urandom_range(0, 2) == 0);
            rden = ($urandom_range(0, 2) == 0);
            mask = 4'($urandom_range(0, 15));
            wdata = $urandom;
            reset_n = !((n % 150) == 149);
            dfi_rst_n = ($urandom_range(0, 199) != 0);
            cyc();
        end
        reset_n = 1;
        dfi_rst_n = 1;
        cke = 1;
        wren = 0;
        rden = 0;
        {cs_n, ras_n, cas_n, we_n} = C_NOP;
        idle(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
